// File: rtl/regfile_pkg.sv
// Shared widths, reset value and types for the RV32 integer register file.
package regfile_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [XLEN-1:0] RESET_VAL = 32'h0000_0005;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam int unsigned DBG_REG_A = 3;
    localparam int unsigned DBG_REG_B = 5;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: 32:1 mux with x0 forced to zero.
// With REGFILE_BYPASS_EN defined, a same-cycle write to rs is forwarded (write-first).
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic [NREGS-1:0][XLEN-1:0] regs,
    input  reg_addr_t                  rs,
    input  logic                       reg_write,
    input  reg_addr_t                  rd,
    input  xlen_t                      wd,
    output xlen_t                      val
);

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        val = regs[rs];
        if (reg_write && (rd != '0) && (rs == rd)) begin
            val = wd;
        end
        if (rs == '0) begin
            val = '0;
        end
    end
`else
    // Write-side inputs only matter for the bypass build.
    logic unused_write_side;
    assign unused_write_side = ^{reg_write, rd, wd};

    always_comb begin
        val = regs[rs];
        if (rs == '0) begin
            val = '0;
        end
    end
`endif

endmodule

// File: rtl/regfile.sv
// RV32 register file: x1..x31 storage with async reset to RESET_VAL, two read ports,
// debug taps on x3/x5. REGFILE_BYPASS_EN enables write-first forwarding on the read ports.
module regfile
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      reg_write,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    input  reg_addr_t rd,
    input  xlen_t     wd,
    output xlen_t     rs1_val,
    output xlen_t     rs2_val,
    output xlen_t     x3_debug,
    output xlen_t     x5_debug
);

    xlen_t                      regs_q [NREGS-1:1];
    logic [NREGS-1:0][XLEN-1:0] regs_flat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else if (reg_write && (rd != '0)) begin
            regs_q[rd] <= wd;
        end
    end

    // x0 has no storage; it is a constant zero in the flattened view.
    always_comb begin
        regs_flat[0] = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            regs_flat[i] = regs_q[i];
        end
    end

    regfile_read_port u_port1 (
        .regs      (regs_flat),
        .rs        (rs1),
        .reg_write (reg_write),
        .rd        (rd),
        .wd        (wd),
        .val       (rs1_val)
    );

    regfile_read_port u_port2 (
        .regs      (regs_flat),
        .rs        (rs2),
        .reg_write (reg_write),
        .rd        (rd),
        .wd        (wd),
        .val       (rs2_val)
    );

    assign x3_debug = regs_flat[DBG_REG_A];
    assign x5_debug = regs_flat[DBG_REG_B];

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus queues expected port values, a negedge monitor checks them.
module tb_regfile;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] x3_debug;
    logic [31:0] x5_debug;

    regfile dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .reg_write(reg_write),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .wd       (wd),
        .rs1_val  (rs1_val),
        .rs2_val  (rs2_val),
        .x3_debug (x3_debug),
        .x5_debug (x5_debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] x3;
        logic [31:0] x5;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] RDW_EXP = 32'h2222_2222;
`else
    localparam logic [31:0] RDW_EXP = 32'h1111_1111;
`endif

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, req);
        end
    endtask

    task automatic expect_vals(input string nm, input logic [31:0] r1, input logic [31:0] r2,
                               input logic [31:0] x3, input logic [31:0] x5);
        exp_t e;
        e.name = nm;
        e.r1   = r1;
        e.r2   = r2;
        e.x3   = x3;
        e.x5   = x5;
        exp_q.push_back(e);
    endtask

    // Inputs change 1 time unit after posedge; the monitor samples at the next negedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp({e.name, ".rs1_val"},  rs1_val,  e.r1);
            cmp({e.name, ".rs2_val"},  rs2_val,  e.r2);
            cmp({e.name, ".x3_debug"}, x3_debug, e.x3);
            cmp({e.name, ".x5_debug"}, x5_debug, e.x5);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        reg_write = 1'b0;
        rs1       = '0;
        rs2       = '0;
        rd        = '0;
        wd        = '0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        rs1 = 5'd0; rs2 = 5'd1;
        expect_vals("reset_a", 32'h0, 32'h5, 32'h5, 32'h5);
        step();
        rs1 = 5'd31; rs2 = 5'd0;
        expect_vals("reset_b", 32'h5, 32'h0, 32'h5, 32'h5);
        step();

        // Basic writes
        reg_write = 1'b1; rd = 5'd3; wd = 32'hCAFE_BABE;
        step();
        rd = 5'd5; wd = 32'hDEAD_BEEF;
        step();
        reg_write = 1'b0; rs1 = 5'd3; rs2 = 5'd5;
        expect_vals("basic", 32'hCAFE_BABE, 32'hDEAD_BEEF, 32'hCAFE_BABE, 32'hDEAD_BEEF);
        step();
        rs1 = 5'd5; rs2 = 5'd5;
        expect_vals("same_reg", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hCAFE_BABE, 32'hDEAD_BEEF);
        step();

        // x0 protect
        reg_write = 1'b1; rd = 5'd0; wd = 32'hFFFF_FFFF;
        step();
        reg_write = 1'b0; rs1 = 5'd0; rs2 = 5'd3;
        expect_vals("x0_protect", 32'h0, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'hDEAD_BEEF);
        step();

        // Read-during-write
        reg_write = 1'b1; rd = 5'd7; wd = 32'h1111_1111;
        step();
        wd = 32'h2222_2222; rs1 = 5'd7; rs2 = 5'd3;
        expect_vals("rdw_before", RDW_EXP, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'hDEAD_BEEF);
        step();
        reg_write = 1'b0;
        expect_vals("rdw_after", 32'h2222_2222, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'hDEAD_BEEF);
        step();

        // Debug tap never bypasses
        reg_write = 1'b1; rd = 5'd3; wd = 32'h3333_3333; rs1 = 5'd0; rs2 = 5'd0;
        expect_vals("tap_before", 32'h0, 32'h0, 32'hCAFE_BABE, 32'hDEAD_BEEF);
        step();
        wd = 32'hCAFE_BABE;
        expect_vals("tap_after", 32'h0, 32'h0, 32'h3333_3333, 32'hDEAD_BEEF);
        step();
        reg_write = 1'b0;

        // Async reset between edges; write during reset is dropped
        #2;
        rst_n = 1'b0;
        reg_write = 1'b1; rd = 5'd3; wd = 32'h1234_5678; rs1 = 5'd3; rs2 = 5'd7;
        expect_vals("async_rst", 32'h5, 32'h5, 32'h5, 32'h5);
        step();
        expect_vals("rst_write_a", 32'h5, 32'h5, 32'h5, 32'h5);
        step();
        rst_n = 1'b1; reg_write = 1'b0;
        expect_vals("rst_write_b", 32'h5, 32'h5, 32'h5, 32'h5);
        step();

        // Full sweep
        reg_write = 1'b1;
        for (int i = 1; i < 32; i++) begin
            rd = 5'(i);
            wd = 32'h100 + 32'(i);
            step();
        end
        reg_write = 1'b0;
        for (int i = 0; i < 32; i++) begin
            logic [31:0] e1;
            logic [31:0] e2;
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            e1 = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
            e2 = (i == 31) ? 32'h0 : 32'h100 + 32'(31 - i);
            expect_vals($sformatf("sweep%0d", i), e1, e2, 32'h103, 32'h105);
            step();
        end

        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
